// File: rtl/flappy_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : flappy_pkg
//  Brief    : Shared geometry, physics constants, FSM encoding and grid helper
//             for the flappy bird datapath.
//  Revision : 1.0 - initial release
// ============================================================================
package flappy_pkg;

    localparam int ROWS     = 30;
    localparam int COLS     = 40;
    localparam int BIRD_X   = 20;
    localparam int BIRD_COL = (156 - BIRD_X) / 4;

    localparam logic [7:0] Y_INIT  = 8'd48;
    localparam logic [7:0] CEIL_Y  = 8'd10;
    localparam logic [7:0] FLOOR_Y = 8'd110;

    localparam logic signed [3:0] GRAVITY  = 4'sd1;
    localparam logic signed [3:0] JUMP_VEL = 4'sd3;
    localparam logic signed [3:0] VMAX     = 4'sd4;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WAIT   = 3'd1,
        S_UPDATE = 3'd2,
        S_CHECK  = 3'd3,
        S_DEAD   = 3'd4
    } state_t;

    // One bit per row of the selected column; bit index = row*COLS + col.
    function automatic logic [ROWS-1:0] col_extract(input logic [ROWS*COLS-1:0] grid,
                                                    input int col);
        logic [ROWS*COLS-1:0] one;
        col_extract = '0;
        one = {{(ROWS*COLS-1){1'b0}}, 1'b1};
        for (int r = 0; r < ROWS; r++) begin
            col_extract[r] = |(grid & (one << (r*COLS + col)));
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/bird_physics_ctrl_edge_detect_rise.sv
`default_nettype none
// ============================================================================
//  Module   : edge_detect_rise
//  Brief    : Two-flop synchroniser followed by a single-cycle rising-edge pulse.
//  Revision : 1.0 - initial release
// ============================================================================
module edge_detect_rise (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic d_i,
    output logic rise_o
);

    logic [1:0] sync_q;
    logic       prev_q;

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            sync_q <= 2'b00;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], d_i};
            prev_q <= sync_q[1];
        end
    end

    assign rise_o = sync_q[1] & ~prev_q;

endmodule
`default_nettype wire

// File: rtl/bird_physics_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : bird_physics_ctrl
//  Brief    : Per-frame bird motion (gravity / jump), ceiling and floor clamp,
//             and collision test against the obstacle grid.
//  Options  : define BIRD_SCORE_EN to add the pipe-passed score counter.
//  Revision : 1.0 - initial release
// ============================================================================
module bird_physics_ctrl
    import flappy_pkg::*;
(
    input  logic                   CLOCK_50,
    input  logic                   resetn,
    input  logic                   frame_tick,
    input  logic                   jump,
    input  logic [ROWS*COLS-1:0]   obstacle_data,
    output logic [7:0]             bird_y,
    output logic [7:0]             prev_y,
    output logic                   moved,
    output logic                   busy,
    output logic                   running,
`ifdef BIRD_SCORE_EN
    output logic [7:0]             score,
`endif
    output logic                   game_over
);

    state_t            state_q;
    logic [7:0]        bird_y_q;
    logic [7:0]        prev_y_q;
    logic signed [3:0] vel_q;
    logic              jump_pend_q;
    logic              floor_hit_q;
    logic              moved_q;

    logic              jump_edge;
    logic signed [3:0] vel_grav;
    logic signed [3:0] vel_d;
    logic signed [8:0] y_sum;
    logic [7:0]        y_d;
    logic              floor_d;
    logic [ROWS-1:0]   col_bits;
    logic [4:0]        r0_idx;
    logic [4:0]        r1_idx;
    logic              hit;

    edge_detect_rise u_jump_edge (
        .clk_i  (CLOCK_50),
        .rstn_i (resetn),
        .d_i    (jump),
        .rise_o (jump_edge)
    );

    always_comb begin
        vel_grav = vel_q + GRAVITY;
        vel_d    = jump_pend_q ? -JUMP_VEL : ((vel_grav > VMAX) ? VMAX : vel_grav);
        y_sum    = $signed({1'b0, bird_y_q}) + $signed({{5{vel_d[3]}}, vel_d});
        y_d      = y_sum[7:0];
        floor_d  = 1'b0;
        if (y_sum <= $signed({1'b0, CEIL_Y})) begin
            y_d = CEIL_Y + 8'd1;
        end
        // Bottom row of the 4x4 box is y+3, so the hit threshold is FLOOR_Y-3.
        if (y_sum >= $signed({1'b0, FLOOR_Y}) - 9'sd3) begin
            y_d     = FLOOR_Y - 8'd4;
            floor_d = 1'b1;
        end
        col_bits = col_extract(obstacle_data, BIRD_COL);
        r0_idx   = bird_y_q[6:2];
        r1_idx   = 5'(({1'b0, bird_y_q} + 9'd3) >> 2);
        hit      = floor_hit_q | col_bits[r0_idx] | col_bits[r1_idx];
    end

`ifdef BIRD_SCORE_EN
    logic [7:0] score_q;
    logic       col_hist_q;
`endif

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            bird_y_q    <= Y_INIT;
            prev_y_q    <= Y_INIT;
            vel_q       <= 4'sd0;
            jump_pend_q <= 1'b0;
            floor_hit_q <= 1'b0;
            moved_q     <= 1'b0;
`ifdef BIRD_SCORE_EN
            score_q     <= 8'd0;
            col_hist_q  <= 1'b0;
`endif
        end else begin
            moved_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (jump_edge) begin
                        state_q     <= S_WAIT;
                        jump_pend_q <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (jump_edge) jump_pend_q <= 1'b1;
                    if (frame_tick) state_q <= S_UPDATE;
                end
                S_UPDATE: begin
                    // A fresh edge in the consuming cycle stays pending for the next frame.
                    jump_pend_q <= jump_edge;
                    vel_q       <= vel_d;
                    prev_y_q    <= bird_y_q;
                    bird_y_q    <= y_d;
                    floor_hit_q <= floor_d;
                    moved_q     <= 1'b1;
                    state_q     <= S_CHECK;
                end
                S_CHECK: begin
                    if (jump_edge) jump_pend_q <= 1'b1;
                    state_q <= hit ? S_DEAD : S_WAIT;
`ifdef BIRD_SCORE_EN
                    col_hist_q <= |col_bits;
                    if (!hit && col_hist_q && !(|col_bits) && score_q != 8'd255) begin
                        score_q <= score_q + 8'd1;
                    end
`endif
                end
                S_DEAD: begin
                    if (jump_edge) begin
                        state_q     <= S_IDLE;
                        bird_y_q    <= Y_INIT;
                        prev_y_q    <= Y_INIT;
                        vel_q       <= 4'sd0;
                        floor_hit_q <= 1'b0;
                        jump_pend_q <= 1'b0;
`ifdef BIRD_SCORE_EN
                        score_q     <= 8'd0;
                        col_hist_q  <= 1'b0;
`endif
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bird_y    = bird_y_q;
    assign prev_y    = prev_y_q;
    assign moved     = moved_q;
    assign busy      = (state_q == S_UPDATE) || (state_q == S_CHECK);
    assign running   = (state_q == S_WAIT) || busy;
    assign game_over = (state_q == S_DEAD);
`ifdef BIRD_SCORE_EN
    assign score     = score_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bird_physics_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bird_physics_ctrl
//  Brief    : Directed self-checking bench for bird_physics_ctrl.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bird_physics_ctrl;
    import flappy_pkg::*;

    logic                 CLOCK_50 = 1'b0;
    logic                 resetn;
    logic                 frame_tick;
    logic                 jump;
    logic [ROWS*COLS-1:0] obstacle_data;
    logic [7:0]           bird_y;
    logic [7:0]           prev_y;
    logic                 moved;
    logic                 busy;
    logic                 running;
    logic                 game_over;
`ifdef BIRD_SCORE_EN
    logic [7:0]           score;
`endif

    int checks = 0;
    int errors = 0;

    always #5 CLOCK_50 = ~CLOCK_50;

    bird_physics_ctrl dut (
        .CLOCK_50      (CLOCK_50),
        .resetn        (resetn),
        .frame_tick    (frame_tick),
        .jump          (jump),
        .obstacle_data (obstacle_data),
        .bird_y        (bird_y),
        .prev_y        (prev_y),
        .moved         (moved),
        .busy          (busy),
        .running       (running),
`ifdef BIRD_SCORE_EN
        .score         (score),
`endif
        .game_over     (game_over)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    task automatic do_reset();
        @(negedge CLOCK_50);
        resetn = 1'b0;
        cyc(3);
        resetn = 1'b1;
        cyc(1);
    endtask

    task automatic do_jump();
        @(negedge CLOCK_50);
        jump = 1'b1;
        cyc(4);
        jump = 1'b0;
        cyc(2);
    endtask

    // Tick sampled at posedge t; UPDATE in t+1, result visible in t+2, verdict in t+3.
    task automatic tick_chk(input string tag, input logic [7:0] ey, input logic [7:0] ep,
                            input logic ego);
        @(negedge CLOCK_50);
        frame_tick = 1'b1;
        @(negedge CLOCK_50);
        frame_tick = 1'b0;
        chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
        cyc(1);
        chk({tag, "_moved"}, {31'd0, moved}, 32'd1);
        chk({tag, "_y"}, {24'd0, bird_y}, {24'd0, ey});
        chk({tag, "_prev"}, {24'd0, prev_y}, {24'd0, ep});
        cyc(1);
        chk({tag, "_moved_end"}, {31'd0, moved}, 32'd0);
        chk({tag, "_go"}, {31'd0, game_over}, {31'd0, ego});
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_y"}, {24'd0, bird_y}, 32'd48);
        chk({tag, "_prev"}, {24'd0, prev_y}, 32'd48);
        chk({tag, "_running"}, {31'd0, running}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_go"}, {31'd0, game_over}, 32'd0);
        chk({tag, "_moved"}, {31'd0, moved}, 32'd0);
    endtask

    initial begin
        int my;
        int mv;
        int ny;
        int n;
        bit hitm;

        resetn        = 1'b0;
        frame_tick    = 1'b0;
        jump          = 1'b0;
        obstacle_data = '0;
        do_reset();
        check_idle("reset");
`ifdef BIRD_SCORE_EN
        chk("reset_score", {24'd0, score}, 32'd0);
`endif

        // Ticks are ignored before the first jump.
        @(negedge CLOCK_50); frame_tick = 1'b1;
        @(negedge CLOCK_50); frame_tick = 1'b0;
        cyc(3);
        check_idle("idle_tick");

        do_jump();
        chk("start_running", {31'd0, running}, 32'd1);
        tick_chk("fall1", 8'd49, 8'd48, 1'b0);
        tick_chk("fall2", 8'd51, 8'd49, 1'b0);
        tick_chk("fall3", 8'd54, 8'd51, 1'b0);

        do_jump();
        tick_chk("jump1", 8'd51, 8'd54, 1'b0);

        // Repeated jumps climb 3 px per frame down to y=12, then clamp at CEIL_Y+1.
        for (int i = 1; i <= 13; i++) begin
            do_jump();
            tick_chk("climb", 8'(51 - 3*i), 8'(54 - 3*i), 1'b0);
        end
        do_jump();
        tick_chk("ceil_clamp", 8'd11, 8'd12, 1'b0);
        tick_chk("ceil_clamp2", 8'd11, 8'd11, 1'b0);
        chk("ceil_running", {31'd0, running}, 32'd1);

        do_reset();
        check_idle("reset2");

        // Free fall to the floor from a fresh start.
        do_jump();
        my   = 48;
        mv   = 0;
        hitm = 1'b0;
        n    = 0;
        while (!hitm && n < 30) begin
            mv = (mv + 1 > 4) ? 4 : mv + 1;
            ny = my + mv;
            if (ny + 3 >= 110) begin
                ny   = 106;
                hitm = 1'b1;
            end
            tick_chk("floor", 8'(ny), 8'(my), hitm);
            my = ny;
            n++;
        end
        chk("floor_reached", {31'd0, hitm}, 32'd1);
        chk("floor_y", {24'd0, bird_y}, 32'd106);

        // Dead: ticks ignored, jump restarts to IDLE.
        @(negedge CLOCK_50); frame_tick = 1'b1;
        @(negedge CLOCK_50); frame_tick = 1'b0;
        cyc(3);
        chk("dead_hold_go", {31'd0, game_over}, 32'd1);
        chk("dead_hold_y", {24'd0, bird_y}, 32'd106);
        chk("dead_running", {31'd0, running}, 32'd0);
        do_jump();
        check_idle("restart");

        // Obstacle exactly at the bird's top row.
        obstacle_data[12*COLS + 34] = 1'b1;
        do_jump();
        tick_chk("obs_hit", 8'd49, 8'd48, 1'b1);
        do_jump();
        check_idle("obs_restart");

        // Neighbouring cells that the 4x4 box at y=49 (rows 12..13) does not touch.
        obstacle_data = '0;
        obstacle_data[11*COLS + 34] = 1'b1;
        obstacle_data[14*COLS + 34] = 1'b1;
        obstacle_data[12*COLS + 33] = 1'b1;
        obstacle_data[13*COLS + 35] = 1'b1;
        do_jump();
        tick_chk("obs_miss", 8'd49, 8'd48, 1'b0);

        // Pipe in column 34 with a gap around the bird, then passed.
        obstacle_data = '0;
        for (int r = 0; r < 4; r++) obstacle_data[r*COLS + 34] = 1'b1;
        tick_chk("pipe1", 8'd51, 8'd49, 1'b0);
        tick_chk("pipe2", 8'd54, 8'd51, 1'b0);
`ifdef BIRD_SCORE_EN
        chk("score_before", {24'd0, score}, 32'd0);
`endif
        obstacle_data = '0;
        tick_chk("pipe_pass", 8'd58, 8'd54, 1'b0);
`ifdef BIRD_SCORE_EN
        chk("score_after", {24'd0, score}, 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
